// File: rtl/mem_seq_pkg.sv
// Shared operation/state encodings and width defaults for the memory vector sequencer.
package mem_seq_pkg;

  localparam int DEF_ADDR_W = 6;
  localparam int DEF_DATA_W = 8;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_XOR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RD   = 2'b01,
    ST_WR   = 2'b10,
    ST_DONE = 2'b11
  } state_e;

endpackage

// File: rtl/mem_seq_if.sv
// Dual-read / single-write data memory port shared by the sequencer (master) and the memory (slave).
interface mem_seq_if import mem_seq_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) ();

  logic              read;
  logic [ADDR_W-1:0] read_adr1;
  logic [ADDR_W-1:0] read_adr2;
  logic [DATA_W-1:0] read_data1;
  logic [DATA_W-1:0] read_data2;
  logic [ADDR_W-1:0] write_adr;
  logic [DATA_W-1:0] write_data;
  logic              write_en;

  modport master (
    output read, read_adr1, read_adr2, write_adr, write_data, write_en,
    input  read_data1, read_data2
  );

  modport slave (
    input  read, read_adr1, read_adr2, write_adr, write_data, write_en,
    output read_data1, read_data2
  );

endinterface

// File: rtl/mem_seq_alu.sv
// Element operation unit: add/sub/and/xor with carry-or-borrow flag.
// Optional MEM_SEQ_SATURATE_EN clamps add/sub results instead of wrapping.
module mem_seq_alu import mem_seq_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W
) (
  input  op_e               i_op,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [DATA_W-1:0] o_result,
  output logic              o_flag
);

  logic [DATA_W:0] w_sum;
  logic [DATA_W:0] w_diff;

  // The extra top bit is the carry for add and the borrow (a < b) for sub.
  assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
  assign w_diff = {1'b0, i_a} - {1'b0, i_b};

  always_comb begin
    o_result = '0;
    o_flag   = 1'b0;
    case (i_op)
      OP_ADD: begin
        o_flag = w_sum[DATA_W];
`ifdef MEM_SEQ_SATURATE_EN
        o_result = w_sum[DATA_W] ? '1 : w_sum[DATA_W-1:0];
`else
        o_result = w_sum[DATA_W-1:0];
`endif
      end
      OP_SUB: begin
        o_flag = w_diff[DATA_W];
`ifdef MEM_SEQ_SATURATE_EN
        o_result = w_diff[DATA_W] ? '0 : w_diff[DATA_W-1:0];
`else
        o_result = w_diff[DATA_W-1:0];
`endif
      end
      OP_AND:  o_result = i_a & i_b;
      OP_XOR:  o_result = i_a ^ i_b;
      default: o_result = '0;
    endcase
  end

endmodule

// File: rtl/mem_seq_ctrl.sv
// Vector sequencer: dst[i] = f(op, src1[i], src2[i]) over length elements, one read and one write cycle each.
// Build option MEM_SEQ_SATURATE_EN selects saturating add/sub in mem_seq_alu.
module mem_seq_ctrl import mem_seq_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [ADDR_W-1:0] src1_base,
  input  logic [ADDR_W-1:0] src2_base,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic [ADDR_W:0]   length,
  output logic              busy,
  output logic              done,
  output logic              ovf,
  mem_seq_if.master         mem
);

  state_e            r_state;
  state_e            w_next;
  op_e               r_op;
  logic [ADDR_W-1:0] r_src1;
  logic [ADDR_W-1:0] r_src2;
  logic [ADDR_W-1:0] r_dst;
  logic [ADDR_W:0]   r_len;
  logic [ADDR_W:0]   r_idx;
  logic [ADDR_W:0]   w_idxInc;
  logic [ADDR_W-1:0] w_off;
  logic [ADDR_W-1:0] r_wrAdr;
  logic [DATA_W-1:0] r_wrData;
  logic              r_ovf;
  logic [DATA_W-1:0] w_result;
  logic              w_flag;

  // Address offsets drop the top idx bit so base+idx wraps around the memory.
  assign w_off    = r_idx[ADDR_W-1:0];
  assign w_idxInc = r_idx + 1'b1;

  mem_seq_alu #(.DATA_W(DATA_W)) u_alu (
    .i_op     (r_op),
    .i_a      (mem.read_data1),
    .i_b      (mem.read_data2),
    .o_result (w_result),
    .o_flag   (w_flag)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_op     <= OP_ADD;
      r_src1   <= '0;
      r_src2   <= '0;
      r_dst    <= '0;
      r_len    <= '0;
      r_idx    <= '0;
      r_wrAdr  <= '0;
      r_wrData <= '0;
      r_ovf    <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_op   <= op_e'(op);
            r_src1 <= src1_base;
            r_src2 <= src2_base;
            r_dst  <= dst_base;
            r_len  <= length;
            r_idx  <= '0;
            r_ovf  <= 1'b0;
          end
        end
        ST_RD: begin
          r_wrAdr  <= r_dst + w_off;
          r_wrData <= w_result;
          if (w_flag) r_ovf <= 1'b1;
        end
        ST_WR:   r_idx <= w_idxInc;
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next         = r_state;
    busy           = (r_state != ST_IDLE);
    done           = (r_state == ST_DONE);
    ovf            = r_ovf;
    mem.read       = 1'b0;
    mem.read_adr1  = '0;
    mem.read_adr2  = '0;
    mem.write_en   = 1'b0;
    mem.write_adr  = r_wrAdr;
    mem.write_data = r_wrData;
    case (r_state)
      ST_IDLE: begin
        if (start) w_next = (length == '0) ? ST_DONE : ST_RD;
      end
      ST_RD: begin
        mem.read      = 1'b1;
        mem.read_adr1 = r_src1 + w_off;
        mem.read_adr2 = r_src2 + w_off;
        w_next        = ST_WR;
      end
      ST_WR: begin
        mem.write_en = 1'b1;
        w_next       = (w_idxInc < r_len) ? ST_RD : ST_DONE;
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

endmodule

// File: doc/mem_seq_ctrl.md
MEM_SEQ_CTRL -- requirements
Module: mem_seq_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 6, word-address width of the attached data memory.
REQ-002 SHALL have parameter DATA_W, default 8, data word width.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-005 SHALL have port start  input  1  request to begin a job; sampled only in IDLE.
REQ-006 SHALL have port op  input  2  operation: 00 add, 01 sub (src1-src2), 10 and, 11 xor.
REQ-007 SHALL have ports src1_base, src2_base, dst_base  input  ADDR_W each  start addresses of the operand and result vectors.
REQ-008 SHALL have port length  input  ADDR_W+1  element count, 0..64.
REQ-009 SHALL have port busy  output  1  high from the cycle after an accepted start until DONE is left.
REQ-010 SHALL have port done  output  1  one-cycle pulse at job completion.
REQ-011 SHALL have port ovf  output  1  sticky flag: carry out (add) or borrow (sub) on any element of the current job.
REQ-012 SHALL have ports read_adr1, read_adr2  output  ADDR_W each, read  output  1  memory read request.
REQ-013 SHALL have ports read_data1, read_data2  input  DATA_W each  combinational memory read data, valid in the same cycle as the addresses.
REQ-014 SHALL have ports write_adr  output  ADDR_W, write_data  output  DATA_W, write_en  output  1  memory write port; the memory captures the write on the next clk edge.

Function
REQ-015 SHALL implement the FSM IDLE -> RD -> WR -> (RD | DONE) -> IDLE.
REQ-016 In IDLE with start=1, SHALL latch op, the three bases and length, clear ovf and idx, then go to RD, or go directly to DONE if length=0.
REQ-017 In RD, SHALL drive read=1, read_adr1=src1_base+idx and read_adr2=src2_base+idx (mod 2^ADDR_W), and register write_adr=dst_base+idx and write_data=f(op, read_data1, read_data2).
REQ-018 In WR, SHALL hold write_en=1 for exactly one cycle, increment idx, then go to RD if idx+1<length, otherwise to DONE.
REQ-019 Each element SHALL take exactly 2 cycles; done SHALL assert 2*length+1 cycles after the start-accept edge (1 cycle for length=0).
REQ-020 Because each write completes before the next read, overlapping source and destination ranges SHALL read already-updated values (no forwarding logic).
REQ-021 Address arithmetic SHALL wrap modulo 64; length=64 SHALL process every word exactly once.
REQ-022 start SHALL be ignored outside IDLE; start held high SHALL start a new job on the cycle after DONE.
REQ-023 read and write_en SHALL never both be high in the same cycle; read SHALL be 0 outside RD.
REQ-024 Arithmetic SHALL be unsigned DATA_W-bit; ovf SHALL be set by carry out of add or by src1<src2 on sub; and/xor SHALL never set it.

Reset
REQ-025 rst SHALL return the FSM to IDLE on the next edge, including in the middle of a job; a partially processed vector SHALL be left as is.
REQ-026 After reset: busy=0, done=0, ovf=0, read=0, write_en=0, all address and data outputs 0.

Configuration
REQ-027 Macro MEM_SEQ_SATURATE_EN, when defined, SHALL clamp add results to 2^DATA_W-1 on carry and sub results to 0 on borrow.
REQ-028 Without MEM_SEQ_SATURATE_EN, results SHALL wrap modulo 2^DATA_W; ovf behaviour SHALL be identical in both builds.

Structure
REQ-029 Package mem_seq_pkg SHALL hold the op encodings, the FSM state encodings and the ADDR_W/DATA_W defaults.
REQ-030 The combinational operation unit (result plus carry/borrow, saturation selection) SHALL be the sub-module mem_seq_alu.

Verification
REQ-031 mem[0..3]=1,2,3,4; op=add, src1=0, src2=2, dst=8, length=2 -> mem[8]=4, mem[9]=6, done on cycle 5, ovf=0.
REQ-032 mem[0]=200, mem[1]=100; op=add, length=1 -> mem[dst]=44 and ovf=1 without the macro; 255 and ovf=1 with it.
REQ-033 mem[0]=3, mem[1]=5; op=sub, src1=0, src2=1, length=1 -> 254 (wrap) or 0 (saturate), ovf=1.
REQ-034 length=0 with start -> done one cycle later, write_en never asserted, memory unchanged.
REQ-035 src1=62, src2=62, dst=62, length=4, op=xor -> addresses 62,63,0,1 all written as 0; no write_en during RD cycles.
REQ-036 rst asserted during WR of element 2 of 5 -> next cycle IDLE, all outputs 0, elements 3-5 unwritten; a new start then runs normally.
